// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display driver:
// FSM state encoding, active-low glyph table and the BCD add-3 step.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEX    = 2'd1,
    ST_CONV   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low {dp,g,f,e,d,c,b,a}, indexed by nibble value 0..F.
  localparam logic [7:0] GLYPH_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg_disp_multi_if.sv
// Load handshake bundle between the value producer (master) and the
// display driver (slave).
interface seg_disp_multi_if #(
  parameter int VALUE_W = 24
);
  logic [VALUE_W-1:0] value;
  logic               mode_dec;
  logic               load_valid;
  logic               load_ready;

  modport master (output value, mode_dec, load_valid, input load_ready);
  modport slave  (input value, mode_dec, load_valid, output load_ready);
endinterface

// File: rtl/seg_glyph_enc.sv
// Combinational nibble to active-low seven-segment glyph (dp always off).
module seg_glyph_enc (
  input  logic [3:0] nib,
  output logic [7:0] seg
);
  import seg_disp_pkg::*;

  assign seg = GLYPH_TBL[nib];

endmodule

// File: rtl/seg_disp_multi.sv
// Multi-digit seven-segment driver with hex or double-dabble decimal rendering.
// Define SEG_DISP_LZB_EN to blank leading zero digits.
//
//   state     | meaning
//   ST_IDLE   | waiting for a load, load_ready high
//   ST_HEX    | one cycle: split value into nibbles, check upper bits
//   ST_CONV   | VALUE_W shift-add-3 iterations
//   ST_UPDATE | copy result and overflow into display registers
module seg_disp_multi
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int VALUE_W    = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  seg_disp_multi_if.slave         ld,
  input  logic                    on_switch,
  output logic [NUM_DIGITS*8-1:0] dig,
  output logic                    busy,
  output logic                    overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int EXT_W = VALUE_W + BCD_W;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               disp_ovf_q, disp_ovf_d;
  logic               disp_vld_q, disp_vld_d;

  logic                     accept;
  logic [EXT_W-1:0]         hex_ext;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+VALUE_W:0]   shifted;
  logic [7:0]               glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]    lzb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      disp_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      disp_ovf_q <= disp_ovf_d;
      disp_vld_q <= disp_vld_d;
    end
  end

  assign accept = ld.load_valid && ld.load_ready;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    disp_ovf_d = disp_ovf_q;
    disp_vld_d = disp_vld_q;

    hex_ext = EXT_W'(bin_q);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
    // MSB of shifted is the bit leaving the top BCD nibble.
    shifted = {bcd_adj, bin_q, 1'b0};

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bin_d   = ld.value;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(VALUE_W);
          state_d = ld.mode_dec ? ST_CONV : ST_HEX;
        end
      end
      ST_HEX: begin
        bcd_d   = hex_ext[BCD_W-1:0];
        ovf_d   = |hex_ext[EXT_W-1:BCD_W];
        state_d = ST_UPDATE;
      end
      ST_CONV: begin
        bcd_d = shifted[BCD_W+VALUE_W-1:VALUE_W];
        bin_d = shifted[VALUE_W-1:0];
        ovf_d = ovf_q | shifted[BCD_W+VALUE_W];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        disp_d     = bcd_q;
        disp_ovf_d = ovf_q;
        disp_vld_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == ST_HEX) || (state_q == ST_CONV);
    ld.load_ready = (state_q == ST_IDLE);
    overflow      = disp_ovf_q;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg_glyph_enc u_enc (
      .nib (disp_q[4*g +: 4]),
      .seg (glyph[g])
    );
  end

  always_comb begin
`ifdef SEG_DISP_LZB_EN
    logic run;
    lzb = '0;
    run = 1'b1;
    // Digit 0 is never blanked so a zero value still shows "0".
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run    = run & (disp_q[4*i +: 4] == 4'h0);
      lzb[i] = run;
    end
`else
    lzb = '0;
`endif
    dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!on_switch || !disp_vld_q) dig[8*i +: 8] = SEG_BLANK;
      else if (disp_ovf_q)           dig[8*i +: 8] = SEG_DASH;
      else if (lzb[i])               dig[8*i +: 8] = SEG_BLANK;
      else                           dig[8*i +: 8] = glyph[i];
    end
  end

endmodule

// File: doc/seg_disp_multi.md
# seg_disp_multi

Parametrised multi-digit seven-segment display driver with a registered load handshake and run-time selectable hexadecimal or decimal rendering. Decimal mode uses a sequential shift-add-3 (double-dabble) converter instead of combinational divide/modulo, so wide values close timing. It sits between any value-producing datapath and the board's seven-segment displays, and holds the last rendered value until a new load completes.

## Interface
- `NUM_DIGITS`, default 6: number of physical displays; digit 0 is rightmost.
- `VALUE_W`, default 24: width of the unsigned input value.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `value` input `VALUE_W`: unsigned value, sampled on an accepted load.
- `mode_dec` input 1: decimal when 1, hex when 0; sampled with `value`.
- `load_valid` input 1: load request.
- `load_ready` output 1: block can accept a load.
- `on_switch` input 1: display enable; 0 blanks all outputs.
- `dig` output `NUM_DIGITS*8`: digit i occupies `dig[8*i+7:8*i]`. Encoding is active-low `{dp,g,f,e,d,c,b,a}`; dp is always 1 (off).
- `busy` output 1: conversion in progress.
- `overflow` output 1: last loaded value did not fit in `NUM_DIGITS`.

## Operation
- Load is accepted on a rising edge where `load_valid && load_ready`. `value` and `mode_dec` are captured on that edge. `load_valid` while `load_ready`=0 is ignored and not queued.
- States:
  - IDLE: `load_ready`=1. On accept, go to HEX when `mode_dec`=0, otherwise to CONV.
  - HEX: one cycle. Nibbles are taken directly. Overflow = any set bit of `value` above bit `4*NUM_DIGITS-1`. Go to UPDATE.
  - CONV: exactly `VALUE_W` iterations, one per cycle. For each iteration, add 3 to every BCD nibble that is ≥5, then shift `{bcd,bin}` left by 1. The BCD register is `4*NUM_DIGITS` bits. Any 1 shifted out of the top nibble sets a sticky overflow flag. Go to UPDATE.
  - UPDATE: latch the nibbles and overflow into the display registers, then go to IDLE.
- In UPDATE with overflow=1, every digit shows dash (8'hBF) and `overflow`=1. Otherwise each digit shows its glyph (0–F) and `overflow`=0.
- Display registers hold their previous contents throughout HEX and CONV.
- `on_switch`=0 forces every `dig` byte to 8'hFF combinationally from the registers. Conversion and the registers are unaffected.
- Reset values:
  - state IDLE
  - display registers blank
  - all `dig` = 8'hFF
  - `overflow`=0, `busy`=0, `load_ready`=1
- Reset mid-conversion aborts immediately. The display is blanked and no partial result is ever shown.

## Timing
- Accept at edge k:
  - Hex: result visible after edge k+2 (HEX, UPDATE).
  - Decimal: result visible after edge k+`VALUE_W`+1.
- `busy` = 1 in HEX and CONV. `load_ready` = 1 only in IDLE, so it returns high the cycle after UPDATE.
- A new load can be accepted on the first edge of IDLE after UPDATE (back-to-back, no bubble beyond UPDATE).
- `dig` and `overflow` change only on the UPDATE edge or on reset.

## Configuration
- `SEG_DISP_LZB_EN` defined: leading-zero blanking. Zero-valued digits above the most significant nonzero digit show 8'hFF. Digit 0 is never blanked, so a value of 0 shows "0". Blanking is not applied on overflow.
- `SEG_DISP_LZB_EN` undefined: all digits show their glyph, including leading zeros (8'hC0).

## Structure
- `seg_disp_pkg` holds:
  - state enum (IDLE, HEX, CONV, UPDATE)
  - glyph table for 0–F
  - constants `SEG_BLANK`=8'hFF and `SEG_DASH`=8'hBF
- Sub-module `seg_glyph_enc`: combinational nibble → active-low 8-bit glyph, instantiated `NUM_DIGITS` times.
- Iteration counter width is `$clog2(VALUE_W+1)`.

## Test plan
- Assert `rst` → all `dig`=8'hFF, `load_ready`=1, `overflow`=0, `busy`=0.
- Hex load of 24'h12AB3F → two edges later, digits 5..0 = F9,A4,88,83,B0,8E; `overflow`=0.
- Decimal load of 146 → `busy` high 24 cycles, result after edge k+25: dig0=82, dig1=99, dig2=F9. Upper digits are C0, or FF with `SEG_DISP_LZB_EN`.
- Decimal load of 1_000_000 → all digits BF, `overflow`=1. A following decimal load of 999_999 → all digits 90, `overflow`=0.
- Second `load_valid` pulse during CONV is ignored. Drop `on_switch` mid-CONV → `dig` all FF. Raise it after UPDATE → first value shown.
- Assert `rst` at CONV cycle 10 → next cycle IDLE, all `dig` FF. A new hex load of 0 then shows C0 on digit 0.
